axis_sample_hold_v2_0: RTL

AXIS_SAMPLE_HOLD_V2_0 -- requirements
Module: axis_sample_hold_v2_0

---
 rtl/axis_sample_hold_v2_0.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/axis_sample_hold_v2_0.sv
// AXI-Stream sample-and-hold with TRACK / DECIM / TRIGGER / FREEZE capture modes.
// Define AXIS_SAMPLE_HOLD_STATUS_EN to add the capture_cnt / overrun_cnt status outputs.
module axis_sample_hold_v2_0 #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNT_WIDTH        = 16,
    parameter int CONTINUOUS       = 1
) (
    input  logic                        aclk,
    input  logic                        arstn,
    input  logic [1:0]                  mode,
    input  logic [CNT_WIDTH-1:0]        decim,
    input  logic                        trig,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        overrun
`ifdef AXIS_SAMPLE_HOLD_STATUS_EN
    ,
    output logic [31:0]                 capture_cnt,
    output logic [15:0]                 overrun_cnt
`endif
);

    localparam logic [1:0] MODE_TRACK   = 2'b00;
    localparam logic [1:0] MODE_DECIM   = 2'b01;
    localparam logic [1:0] MODE_TRIGGER = 2'b10;

    logic [1:0]                  mode_q;
    logic                        trig_q;
    logic                        armed_q, armed_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]        n_act_q, n_act_d;
    logic [AXIS_TDATA_WIDTH-1:0] hold_q;
    logic                        tvalid_q, tvalid_d;
    logic                        overrun_q, overrun_d;

    logic                        mode_chg;
    logic                        accept;
    logic                        trig_rise;
    logic                        armed_eff;
    logic [CNT_WIDTH-1:0]        cnt_eff;
    logic [CNT_WIDTH-1:0]        n_use;
    logic                        cnt_last;
    logic                        capture;

    // Both stream sides use valid/ready: a beat moves on a rising aclk edge where
    // tvalid and tready are both high; the input side is always ready out of reset.
    assign s_axis_tready = arstn;
    assign m_axis_tdata  = hold_q;
    assign m_axis_tvalid = tvalid_q;
    assign overrun       = overrun_q;

    always_comb begin
        mode_chg  = (mode != mode_q);
        accept    = s_axis_tvalid & s_axis_tready;
        trig_rise = trig & ~trig_q;
        cnt_eff   = mode_chg ? '0 : cnt_q;
        armed_eff = mode_chg ? 1'b0 : armed_q;
        // A new divisor is picked up only when the count restarts at zero
        n_use     = (cnt_eff == '0) ? decim : n_act_q;
        cnt_last  = (n_use <= CNT_WIDTH'(1)) || (cnt_eff >= (n_use - CNT_WIDTH'(1)));

        capture = 1'b0;
        cnt_d   = cnt_eff;
        armed_d = armed_eff;
        n_act_d = n_act_q;

        case (mode)
            MODE_TRACK: begin
                capture = accept;
            end
            MODE_DECIM: begin
                if (accept) begin
                    capture = (cnt_eff == '0);
                    if (cnt_eff == '0) begin
                        n_act_d = decim;
                    end
                    cnt_d = cnt_last ? '0 : cnt_eff + CNT_WIDTH'(1);
                end
            end
            MODE_TRIGGER: begin
                if (armed_eff) begin
                    if (accept) begin
                        capture = 1'b1;
                        armed_d = 1'b0;
                    end
                end else if (trig_rise) begin
                    armed_d = 1'b1;
                end
            end
            default: begin
            end
        endcase

        if (CONTINUOUS != 0) begin
            tvalid_d  = 1'b1;
            overrun_d = 1'b0;
        end else begin
            tvalid_d  = capture | (tvalid_q & ~m_axis_tready);
            overrun_d = capture & tvalid_q & ~m_axis_tready;
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            mode_q    <= MODE_TRACK;
            trig_q    <= 1'b0;
            armed_q   <= 1'b0;
            cnt_q     <= '0;
            n_act_q   <= '0;
            hold_q    <= '0;
            tvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            mode_q    <= mode;
            trig_q    <= trig;
            armed_q   <= armed_d;
            cnt_q     <= cnt_d;
            n_act_q   <= n_act_d;
            tvalid_q  <= tvalid_d;
            overrun_q <= overrun_d;
            if (capture) begin
                hold_q <= s_axis_tdata;
            end
        end
    end

`ifdef AXIS_SAMPLE_HOLD_STATUS_EN
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            capture_cnt <= '0;
            overrun_cnt <= '0;
        end else begin
            if (capture) begin
                capture_cnt <= capture_cnt + 32'd1;
            end
            if (overrun_d && (overrun_cnt != 16'hFFFF)) begin
                overrun_cnt <= overrun_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
